// File: rtl/cia_serial_link.sv
// cia_serial_link
//   Bit-serial link that talks to a 6526 CIA serial port (CNT/SP pins).
//   Transmits bytes MSB first by generating CNT pulses of HALF_PERIOD phi2
//   cycles per half, with GAP idle phi2 cycles after each byte. Receives
//   bytes MSB first by sampling SP on CNT rising edges, discarding a partial
//   byte after RX_TIMEOUT phi2 cycles without an edge. Receive only runs
//   while the transmitter is idle; a new transmit waits for a partial receive.
//
// Ports
//   clk, reset        : system clock, asynchronous active-high reset
//   phi2_p            : one-clk enable; all state advances only on it
//   cnt_in, sp_in     : CNT / SP from the CIA
//   cnt_out, sp_out   : CNT / SP towards the CIA (idle high)
//   tx_data/valid/ready : transmit byte handshake
//   rx_data           : last received byte
//   rx_valid          : one-clk pulse when rx_data updates
//   rx_abort          : one-clk pulse when a partial byte is discarded
module cia_serial_link #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP         = 2,
  parameter int RX_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic       cnt_out,
  output logic       sp_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_abort
);

  localparam int TOW = $clog2(RX_TIMEOUT + 1);
  localparam logic [7:0]     HP_LOAD  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0]     GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [TOW-1:0] TO_LAST  = TOW'(RX_TIMEOUT - 1);
  localparam logic [TOW-1:0] TO_ZERO  = {TOW{1'b0}};
  localparam logic [TOW-1:0] TO_ONE   = TOW'(1'b1);

  typedef enum logic [1:0] {IDLE, TX_LOW, TX_HIGH, TX_GAP} tx_state_t;

  tx_state_t      state_r, state_s;
  logic [7:0]     timer_r, timer_s;
  logic [7:0]     shift_r, shift_s;
  logic [2:0]     bit_cnt_r, bit_cnt_s;
  logic           cnt_prev_r;
  logic [7:0]     rx_sh_r, rx_sh_s;
  logic [2:0]     rx_cnt_r, rx_cnt_s;
  logic [TOW-1:0] to_r, to_s;
  logic [7:0]     rx_data_r, rx_data_s;
  logic           rx_valid_r, rx_valid_s;
  logic           rx_abort_r, rx_abort_s;
  logic           cnt_out_r, cnt_out_s;
  logic           sp_out_r, sp_out_s;
  logic           tx_ready_r, tx_ready_s;
  logic           accept_s;
  logic           rise_s;

  // tx_ready_r already encodes "idle with no partial receive", so it gates acceptance.
  assign accept_s = phi2_p & tx_valid & tx_ready_r;
  assign rise_s   = cnt_in & ~cnt_prev_r;

  assign cnt_out  = cnt_out_r;
  assign sp_out   = sp_out_r;
  assign tx_ready = tx_ready_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign rx_abort = rx_abort_r;

  // Transmit FSM next state, half-period timer and shift register.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    if (phi2_p) begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s   = TX_LOW;
            shift_s   = tx_data;
            bit_cnt_s = 3'd0;
            timer_s   = HP_LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        TX_LOW: begin
          if (timer_r == 8'd0) begin
            state_s = TX_HIGH;
            timer_s = HP_LOAD;
          end else begin
            timer_s = timer_r - 8'd1;
          end
        end
        TX_HIGH: begin
          if (timer_r == 8'd0) begin
            shift_s   = {shift_r[6:0], 1'b1};
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r != 3'd7) begin
              state_s = TX_LOW;
              timer_s = HP_LOAD;
            end else if (GAP == 0) begin
              state_s = IDLE;
            end else begin
              state_s = TX_GAP;
              timer_s = GAP_LOAD;
            end
          end else begin
            timer_s = timer_r - 8'd1;
          end
        end
        TX_GAP: begin
          if (timer_r == 8'd0) begin
            state_s = IDLE;
          end else begin
            timer_s = timer_r - 8'd1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Receiver: shifter, bit count and inactivity timeout; idle-TX only, and a
  // simultaneous accept takes priority over a CNT edge.
  always_comb begin
    rx_sh_s    = rx_sh_r;
    rx_cnt_s   = rx_cnt_r;
    to_s       = to_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    rx_abort_s = 1'b0;
    if (phi2_p && (state_r == IDLE) && !accept_s) begin
      if (rise_s) begin
        rx_sh_s  = {rx_sh_r[6:0], sp_in};
        rx_cnt_s = rx_cnt_r + 3'd1;
        to_s     = TO_ZERO;
        if (rx_cnt_r == 3'd7) begin
          rx_data_s  = {rx_sh_r[6:0], sp_in};
          rx_valid_s = 1'b1;
        end else begin
          rx_valid_s = 1'b0;
        end
      end else if (rx_cnt_r != 3'd0) begin
        if (to_r == TO_LAST) begin
          rx_cnt_s   = 3'd0;
          rx_sh_s    = 8'h00;
          to_s       = TO_ZERO;
          rx_abort_s = 1'b1;
        end else begin
          to_s = to_r + TO_ONE;
        end
      end else begin
        to_s = TO_ZERO;
      end
    end else begin
      rx_valid_s = 1'b0;
    end
  end

  // Output values derived from the next state so the pins come straight from flops.
  always_comb begin
    cnt_out_s  = (state_s != TX_LOW);
    tx_ready_s = (state_s == IDLE) && (rx_cnt_s == 3'd0);
    if ((state_s == TX_LOW) || (state_s == TX_HIGH)) begin
      sp_out_s = shift_s[7];
    end else begin
      sp_out_s = 1'b1;
    end
  end

  // Transmit-side registers and the registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= 8'd0;
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      cnt_out_r  <= 1'b1;
      sp_out_r   <= 1'b1;
      tx_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      cnt_out_r  <= cnt_out_s;
      sp_out_r   <= sp_out_s;
      tx_ready_r <= tx_ready_s;
    end
  end

  // Receive-side registers; pulses clear on any clk without phi2_p.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_prev_r <= 1'b1;
      rx_sh_r    <= 8'h00;
      rx_cnt_r   <= 3'd0;
      to_r       <= TO_ZERO;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_abort_r <= 1'b0;
    end else begin
      if (phi2_p) begin
        cnt_prev_r <= cnt_in;
      end else begin
        cnt_prev_r <= cnt_prev_r;
      end
      rx_sh_r    <= rx_sh_s;
      rx_cnt_r   <= rx_cnt_s;
      to_r       <= to_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      rx_abort_r <= rx_abort_s;
    end
  end

endmodule

// File: tb/tb_cia_serial_link.sv
// Self-checking bench for cia_serial_link. A transaction-level model tracks
// the position inside the current transmitted byte and the list of received
// bits; every clk the DUT outputs are compared against it. Directed scenarios
// add hand-computed literal expectations; a random phase follows.
module tb_cia_serial_link;
  localparam int HP = 4;
  localparam int GP = 2;
  localparam int TO = 64;
  localparam int BYTE_LEN = 16 * HP + GP;

  logic clk = 1'b0;
  logic reset, phi2_p, cnt_in, sp_in, cnt_out, sp_out;
  logic tx_valid, tx_ready, rx_valid, rx_abort;
  logic [7:0] tx_data, rx_data;

  cia_serial_link #(.HALF_PERIOD(HP), .GAP(GP), .RX_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .phi2_p(phi2_p), .cnt_in(cnt_in), .sp_in(sp_in),
    .cnt_out(cnt_out), .sp_out(sp_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_abort(rx_abort)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  int         m_pos;      // phi2 edges since accept, -1 when not transmitting
  logic [7:0] m_tx_byte;
  int         m_rx_val;   // bits assembled so far, as a number
  int         m_rx_n;     // bits received so far
  int         m_quiet;    // phi2 cycles since the last counted edge
  logic [7:0] m_rx_data;
  logic       m_prev, m_rv, m_ra, m_acc;
  int         div = 0;
  int         rv_seen, ra_seen, ready_hi;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_cnt();
    if (m_pos < 0 || m_pos >= 16 * HP) return 1'b1;
    return (m_pos % (2 * HP)) >= HP;
  endfunction

  function automatic logic exp_sp();
    if (m_pos < 0 || m_pos >= 16 * HP) return 1'b1;
    return m_tx_byte[7 - m_pos / (2 * HP)];
  endfunction

  task automatic model_reset();
    m_pos = -1; m_tx_byte = 8'h00; m_rx_val = 0; m_rx_n = 0; m_quiet = 0;
    m_rx_data = 8'h00; m_prev = 1'b1; m_rv = 1'b0; m_ra = 1'b0; m_acc = 1'b0;
  endtask

  task automatic model_phi();
    logic ready;
    logic rise;
    ready = (m_pos < 0) && (m_rx_n == 0);
    rise  = cnt_in && !m_prev;
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos >= BYTE_LEN) m_pos = -1;
    end else if (tx_valid && ready) begin
      m_pos = 0; m_tx_byte = tx_data; m_acc = 1'b1;
    end else if (rise) begin
      m_rx_val = (m_rx_val * 2 + int'(sp_in)) % 256;
      m_rx_n++;
      m_quiet = 0;
      if (m_rx_n == 8) begin
        m_rx_data = 8'(m_rx_val); m_rv = 1'b1; m_rx_n = 0; m_rx_val = 0;
      end
    end else if (m_rx_n != 0) begin
      m_quiet++;
      if (m_quiet == TO) begin
        m_rx_n = 0; m_rx_val = 0; m_quiet = 0; m_ra = 1'b1;
      end
    end
    m_prev = cnt_in;
  endtask

  // one clk: advance model, compare every output, source drops tx_valid once accepted
  task automatic cyc();
    phi2_p = (div == 0);
    div = (div + 1) % 2;
    @(posedge clk);
    #1;
    m_acc = 1'b0; m_rv = 1'b0; m_ra = 1'b0;
    if (reset) model_reset();
    else if (phi2_p) model_phi();
    if (rx_valid) rv_seen++;
    if (rx_abort) ra_seen++;
    if (tx_ready) ready_hi++;
    check("cnt_out", cnt_out, exp_cnt());
    check("sp_out", sp_out, exp_sp());
    check("tx_ready", tx_ready, (m_pos < 0) && (m_rx_n == 0));
    check("rx_data", rx_data, m_rx_data);
    check("rx_valid", rx_valid, m_rv);
    check("rx_abort", rx_abort, m_ra);
    if (m_acc) tx_valid = 1'b0;
  endtask

  task automatic phi();
    do cyc(); while (!phi2_p);
  endtask

  task automatic send_bit(input logic b, input int hp);
    cnt_in = 1'b0; sp_in = b;
    repeat (hp) phi();
    cnt_in = 1'b1;
    repeat (hp) phi();
  endtask

  task automatic send_byte(input logic [7:0] v, input int hp, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(v[7 - i], hp);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (tx_valid && n < 400) begin phi(); n++; end
    check("accept_wait", tx_valid, 1'b0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin phi(); n++; end
    check("ready_wait", tx_ready, 1'b1);
  endtask

  initial begin
    int n, lows, low_phis;
    logic prev;
    logic [7:0] cap;
    reset = 1'b1; cnt_in = 1'b1; sp_in = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    phi2_p = 1'b0;
    rv_seen = 0; ra_seen = 0; ready_hi = 0;
    model_reset();
    #2;
    check("rst_cnt_out", cnt_out, 1'b1);
    check("rst_sp_out", sp_out, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_abort", rx_abort, 1'b0);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (4) cyc();

    // transmit A5: 8 low pulses of HP phi2, bits 1,0,1,0,0,1,0,1, ready after 66
    tx_data = 8'hA5; tx_valid = 1'b1;
    phi();
    n = 0; prev = 1'b1; cap = 8'h00; lows = 0; low_phis = 0;
    while (!tx_ready && n < 300) begin
      if (!cnt_out && prev) begin cap = {cap[6:0], sp_out}; lows++; end
      if (!cnt_out) low_phis++;
      prev = cnt_out;
      phi(); n++;
    end
    check("a5_ready_phis", 8'(n), 8'd66);
    check("a5_sp_bits", cap, 8'b1010_0101);
    check("a5_low_pulses", 8'(lows), 8'd8);
    check("a5_low_phis", 8'(low_phis), 8'd32);

    // receive 0,0,1,1,1,1,0,0
    rv_seen = 0;
    send_byte(8'h3C, 2, 8);
    repeat (3) phi();
    check("rx_3c", rx_data, 8'h3C);
    check("rx_3c_pulses", 8'(rv_seen), 8'd1);

    // 3 bits then silence: one abort, data kept, then FF
    ra_seen = 0; rv_seen = 0;
    send_byte(8'hA0, 2, 3);
    cnt_in = 1'b1;
    repeat (70) phi();
    check("abort_pulses", 8'(ra_seen), 8'd1);
    check("abort_keeps", rx_data, 8'h3C);
    send_byte(8'hFF, 2, 8);
    repeat (2) phi();
    check("rx_ff", rx_data, 8'hFF);
    check("rx_ff_pulses", 8'(rv_seen), 8'd1);

    // tx request after 2 received bits waits for the 8th bit
    send_byte(8'h96, 2, 2);
    tx_valid = 1'b1; tx_data = 8'h3A;
    ready_hi = 0;
    for (int i = 2; i < 7; i++) send_bit(i[0] ? 1'b0 : 1'b1, 2);
    cnt_in = 1'b0; sp_in = 1'b0;
    repeat (2) phi();
    check("hold_ready_low", 8'(ready_hi), 8'd0);
    cnt_in = 1'b1;
    phi();
    check("hold_rx_byte", rx_data, 8'hAA);
    phi();
    check("hold_tx_starts", cnt_out, 1'b0);
    wait_ready();

    // reset during bit 5 of a transmit
    tx_data = 8'hC3; tx_valid = 1'b1;
    phi();
    repeat (17) phi();
    reset = 1'b1;
    #1;
    check("rst_mid_cnt", cnt_out, 1'b1);
    check("rst_mid_sp", sp_out, 1'b1);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) cyc();
    check("rst_mid_ready", tx_ready, 1'b1);
    tx_data = 8'h80; tx_valid = 1'b1;
    phi();
    check("post_rst_bit7_cnt", cnt_out, 1'b0);
    check("post_rst_bit7_sp", sp_out, 1'b1);
    wait_ready();

    // loopback against a CIA-like partner: it sends 5A, then receives 5A
    send_byte(8'h5A, 4, 8);
    repeat (2) phi();
    check("cia_to_link", rx_data, 8'h5A);
    tx_data = 8'h5A; tx_valid = 1'b1;
    phi();
    n = 0; prev = cnt_out; cap = 8'h00; lows = 0;
    while (!tx_ready && n < 300) begin
      if (cnt_out && !prev) begin cap = {cap[6:0], sp_out}; lows++; end
      prev = cnt_out;
      phi(); n++;
    end
    check("link_to_cia", cap, 8'h5A);
    check("cia_icr3", (lows == 8) ? 8'd1 : 8'd0, 8'd1);

    // random traffic against the model
    for (int it = 0; it < 120; it++) begin
      if (tx_valid) wait_accept();
      case ($urandom_range(0, 3))
        0: begin
          tx_data = 8'($urandom); tx_valid = 1'b1;
          wait_accept();
          repeat ($urandom_range(0, 100)) begin
            cnt_in = 1'($urandom); sp_in = 1'($urandom); phi();
          end
        end
        1: begin
          send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 8));
          cnt_in = 1'b1;
          repeat ($urandom_range(0, 80)) phi();
        end
        2: begin
          wait_ready();
          cnt_in = 1'b0; phi();
          cnt_in = 1'b1; tx_valid = 1'b1; tx_data = 8'($urandom);
          phi();
        end
        default: begin
          repeat (20) begin
            cnt_in = 1'($urandom); sp_in = 1'($urandom);
            if (!tx_valid && $urandom_range(0, 7) == 0) begin
              tx_valid = 1'b1; tx_data = 8'($urandom);
            end
            phi();
          end
        end
      endcase
    end
    if (tx_valid) wait_accept();
    cnt_in = 1'b1;
    wait_ready();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cia_serial_link.md
CIA_SERIAL_LINK -- requirements
Module: cia_serial_link

Interface
REQ-001 Parameter HALF_PERIOD, default 4: phi2 cycles per CNT half-period when transmitting; legal range 1..255.
REQ-002 Parameter GAP, default 2: idle phi2 cycles after each transmitted byte; legal range 0..255.
REQ-003 Parameter RX_TIMEOUT, default 64: phi2 cycles without a CNT rising edge after which a partial received byte is discarded.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 phi2_p  in  1  one-clk Phi 2 positive-edge enable; all state advances only on clk edges where phi2_p=1.
REQ-007 cnt_in  in  1  CNT line from the CIA (CIA cnt_out).
REQ-008 sp_in  in  1  SP data from the CIA (CIA sp_out).
REQ-009 cnt_out  out  1  CNT line driven towards the CIA cnt_in; idle level 1.
REQ-010 sp_out  out  1  SP data driven towards the CIA sp_in; idle level 1.
REQ-011 tx_data  in  8  byte to send; sampled when tx_valid&tx_ready&phi2_p.
REQ-012 tx_valid  in  1  transmit request; held by the source until accepted.
REQ-013 tx_ready  out  1  high when a byte can be accepted.
REQ-014 rx_data  out  8  last received byte; holds until the next byte completes.
REQ-015 rx_valid  out  1  one-clk pulse when rx_data updates.
REQ-016 rx_abort  out  1  one-clk pulse when a partial byte is discarded on timeout.

Function
REQ-017 The bit order SHALL be MSB first in both directions.
REQ-018 On each phi2_p the block SHALL register cnt_in into cnt_prev; a rising edge SHALL be cnt_in=1 & cnt_prev=0.
REQ-019 TX state machine states SHALL be IDLE, TX_LOW, TX_HIGH, TX_GAP.
REQ-020 tx_ready SHALL be 1 only in IDLE with rx bit count 0.
REQ-021 IDLE->TX_LOW on accept: shift register <= tx_data, bit count <= 0, timer <= HALF_PERIOD-1.
REQ-022 In TX_LOW, cnt_out SHALL be 0 and sp_out SHALL equal shift[7]; when the timer reaches 0 -> TX_HIGH, timer reloaded.
REQ-023 In TX_HIGH, cnt_out SHALL be 1 with sp_out unchanged; at timer 0 the shift register SHALL shift left, bit count SHALL increment, and the next state SHALL be TX_LOW if bit count<7, else TX_GAP.
REQ-024 In TX_GAP, cnt_out=1 and sp_out=1 for GAP phi2 cycles, then IDLE; GAP=0 SHALL go directly to IDLE.
REQ-025 One byte SHALL therefore occupy 16*HALF_PERIOD+GAP phi2 cycles from accept to tx_ready reasserting.
REQ-026 The receiver SHALL operate only while the TX state is IDLE; cnt_in edges in other states SHALL be ignored.
REQ-027 On a rising edge the receiver SHALL shift sp_in (sampled on that same phi2_p) into bit 0, increment a 3-bit count and reset the timeout counter.
REQ-028 When the 8th bit is sampled: rx_data <= assembled byte, rx_valid pulses on that clk, count wraps to 0.
REQ-029 With count nonzero and no rising edge for RX_TIMEOUT phi2 cycles: count <= 0, shifter cleared, rx_abort pulses, rx_data unchanged.
REQ-030 tx_valid arriving with a partial receive in progress SHALL wait; no byte is accepted until the receive completes or times out.
REQ-031 tx_valid and a rising edge on the same phi2_p with rx count 0: transmit SHALL win, and the edge SHALL be ignored.
REQ-032 Without phi2_p, no state, output or counter SHALL change, except rx_valid and rx_abort returning to 0.

Reset
REQ-033 While reset=1: state IDLE, cnt_out=1, sp_out=1, tx_ready=1, rx_data=8'h00, rx_valid=0, rx_abort=0, all counters 0, cnt_prev=1.
REQ-034 Reset mid-byte SHALL abort the transfer immediately (asynchronously), with no rx_valid and no further CNT edges.

Verification
REQ-035 HALF_PERIOD=4, GAP=2, send 8'hA5 -> 8 CNT low/high pulses of 4 phi2 each; sp_out during lows = 1,0,1,0,0,1,0,1; tx_ready returns after 66 phi2 cycles.
REQ-036 Drive 8 CNT rising edges with sp_in = 0,0,1,1,1,1,0,0 -> rx_data=8'h3C, with a single rx_valid pulse on the 8th edge.
REQ-037 Drive 3 bits, then idle for 64 phi2 cycles -> rx_abort pulses once, rx_data is unchanged, and a following 8-bit 8'hFF is received correctly.
REQ-038 Assert tx_valid after 2 received bits -> tx_ready=0 until the 8th bit is received; transmit then starts on the next phi2_p.
REQ-039 Assert reset during bit 5 of a transmit -> cnt_out=1 and sp_out=1 at once; after release, tx_ready=1 and a new byte transmits from bit 7.
REQ-040 Loopback to the CIA model (CIA in input mode, then output mode, timer A=3) -> 8'h5A is exchanged both ways, and the CIA sets icr[3].
